// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer: FSM encoding and default sizes.
package pattern_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH     = 12;
    localparam int DEFAULT_DIV_WIDTH = 27;

endpackage

// File: rtl/bit_period_divider.sv
// Loadable down-counter used as a slowed-down tick source; zero marks the tick.
module bit_period_divider
    import pattern_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_value,
    input  logic                 hold,
    output logic                 zero
);

    logic [DIV_WIDTH-1:0] count;

    // Load wins over hold so a new period can start even while frozen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!hold && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-load serializer: accepts a pattern on a valid/ready handshake and shifts
// it out one bit per divisor+1 clocks, with pause, auto-repeat and back-to-back loads.
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WIDTH-1:0]     load_data,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 repeat_en,
    input  logic                 pause,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 bit_strobe,
    output logic                 done
);

    // Handshake: a pattern transfers in any cycle where load_valid and load_ready are
    // both high; load_ready never depends on load_valid.

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t               state, state_n;
    logic [WIDTH-1:0]     shift_reg, shift_n;
    logic [WIDTH-1:0]     repeat_reg, repeat_n;
    logic [DIV_WIDTH-1:0] period_reg, period_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 bit_out_n, bit_valid_n, bit_strobe_n, done_n;
    logic                 cnt_load, cnt_zero;
    logic [DIV_WIDTH-1:0] cnt_value;
    logic                 tick, final_tick, accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] p);
        return MSB_FIRST ? p[WIDTH-1] : p[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] p);
        return MSB_FIRST ? {p[WIDTH-2:0], 1'b0} : {1'b0, p[WIDTH-1:1]};
    endfunction

    bit_period_divider #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .load_value(cnt_value),
        .hold      (pause),
        .zero      (cnt_zero)
    );

    always_comb begin
        tick         = (state == SHIFT) && cnt_zero && !pause;
        final_tick   = tick && (idx == LAST_IDX);
        load_ready   = (state == IDLE) || final_tick;
        accept       = load_valid && load_ready;

        state_n      = state;
        shift_n      = shift_reg;
        repeat_n     = repeat_reg;
        period_n     = period_reg;
        idx_n        = idx;
        cnt_load     = 1'b0;
        cnt_value    = period_reg;
        bit_out_n    = bit_out;
        bit_valid_n  = bit_valid;
        bit_strobe_n = 1'b0;
        done_n       = final_tick;

        if (accept) begin
            state_n      = SHIFT;
            shift_n      = load_data;
            repeat_n     = load_data;
            period_n     = divisor;
            idx_n        = '0;
            cnt_load     = 1'b1;
            cnt_value    = divisor;
            bit_out_n    = first_bit(load_data);
            bit_valid_n  = 1'b1;
            bit_strobe_n = 1'b1;
        end else if (final_tick && repeat_en) begin
            shift_n      = repeat_reg;
            idx_n        = '0;
            cnt_load     = 1'b1;
            bit_out_n    = first_bit(repeat_reg);
            bit_strobe_n = 1'b1;
        end else if (final_tick) begin
            state_n      = IDLE;
            bit_out_n    = 1'b0;
            bit_valid_n  = 1'b0;
        end else if (tick) begin
            shift_n      = advance(shift_reg);
            idx_n        = idx + 1'b1;
            cnt_load     = 1'b1;
            bit_out_n    = first_bit(advance(shift_reg));
            bit_strobe_n = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            repeat_reg <= '0;
            period_reg <= '0;
            idx        <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            repeat_reg <= repeat_n;
            period_reg <= period_n;
            idx        <= idx_n;
            bit_out    <= bit_out_n;
            bit_valid  <= bit_valid_n;
            bit_strobe <= bit_strobe_n;
            done       <= done_n;
        end
    end

endmodule
